// File: rtl/mmu_ctx_if.sv
// rtl/mmu_ctx_if.sv - core-side and SR-side bus bundle for the multi-context MMU
// Purpose: groups the translation handshake, SR write port, flush control and
//          fault latch readback of mmu_ctx into one interface.
// Ports (signals):
//   req/ready/addr/we/ctx/paging_en : translation request (master -> slave, ready back)
//   ack/ext_addr/fault              : registered translation result
//   sr_sel/sr_data/sr_ie            : SR write port (table window + wr_ctx select)
//   flush/flush_ctx/busy            : context flush control and status
//   fault_clr/fault_addr/fault_info : fault latch (active only with MMU_FAULT_LATCH_EN)
// Modports: master = core / bench side, slave = mmu_ctx.
interface mmu_ctx_if #(
  parameter int ADDR_W      = 16,
  parameter int PAGE_BITS   = 4,
  parameter int PHYS_PAGE_W = 12,
  parameter int CTX_N       = 4,
  parameter int RW          = 16
);
  localparam int CTX_W = $clog2(CTX_N);
  localparam int EXT_W = PHYS_PAGE_W + ADDR_W - PAGE_BITS;

  logic              req;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [CTX_W-1:0]  ctx;
  logic              paging_en;
  logic              ack;
  logic [EXT_W-1:0]  ext_addr;
  logic              fault;
  logic [RW-1:0]     sr_sel;
  logic [RW-1:0]     sr_data;
  logic              sr_ie;
  logic              flush;
  logic [CTX_W-1:0]  flush_ctx;
  logic              busy;
  logic              fault_clr;
  logic [ADDR_W-1:0] fault_addr;
  logic [CTX_W+1:0]  fault_info;

  modport master (
    output req, addr, we, ctx, paging_en, sr_sel, sr_data, sr_ie,
           flush, flush_ctx, fault_clr,
    input  ready, ack, ext_addr, fault, busy, fault_addr, fault_info
  );

  modport slave (
    input  req, addr, we, ctx, paging_en, sr_sel, sr_data, sr_ie,
           flush, flush_ctx, fault_clr,
    output ready, ack, ext_addr, fault, busy, fault_addr, fault_info
  );
endinterface

// File: rtl/mmu_ctx.sv
// rtl/mmu_ctx.sv - multi-context paged MMU with registered translation and flush FSM
// Purpose: translates logical addresses through a per-context page table
//          (valid, write-protect, ppn) with one-cycle latency and fault
//          reporting; a flush FSM invalidates one context, one entry per cycle.
// Ports:
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset (clears all tables, FSM, latch)
//   bus     : mmu_ctx_if.slave (request/result, SR writes, flush, fault latch)
// Configuration: define MMU_FAULT_LATCH_EN to enable the first-fault latch;
//   otherwise fault_addr/fault_info read 0 and fault_clr is ignored.
module mmu_ctx #(
  parameter int ADDR_W      = 16,
  parameter int PAGE_BITS   = 4,
  parameter int PHYS_PAGE_W = 12,
  parameter int CTX_N       = 4,
  parameter int RW          = 16,
  parameter int SR_BASE     = 16
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  mmu_ctx_if.slave bus
);
  localparam int ENT   = 1 << PAGE_BITS;
  localparam int CTX_W = $clog2(CTX_N);
  localparam int EXT_W = PHYS_PAGE_W + ADDR_W - PAGE_BITS;
  localparam int OFF_W = ADDR_W - PAGE_BITS;
  localparam int E_W   = PHYS_PAGE_W + 2;  // {valid, wp, ppn}

  localparam logic [RW-1:0] WIN_LO  = RW'(SR_BASE);
  localparam logic [RW-1:0] CTX_SEL = RW'(SR_BASE + ENT);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [E_W-1:0]       tbl [CTX_N][ENT];
  logic [CTX_W-1:0]     wr_ctx;
  logic [CTX_W-1:0]     fctx;
  logic [PAGE_BITS-1:0] idx;
  logic [0:0]           state;

  // SR decode
  logic                 in_win;
  logic [RW-1:0]        sel_off;
  logic [PAGE_BITS-1:0] win_idx;
  logic [E_W-1:0]       new_ent;

  assign sel_off = bus.sr_sel - WIN_LO;
  assign win_idx = sel_off[PAGE_BITS-1:0];
  assign in_win  = bus.sr_ie && (bus.sr_sel >= WIN_LO) && (bus.sr_sel < CTX_SEL);
  assign new_ent = {bus.sr_data[RW-1], bus.sr_data[RW-2], bus.sr_data[PHYS_PAGE_W-1:0]};

  // Lookup uses the pre-edge table, so a same-cycle SR write is not yet visible
  logic [PAGE_BITS-1:0] page;
  logic [E_W-1:0]       look;
  logic                 t_valid, t_wp, t_fault, accept;
  logic [EXT_W-1:0]     t_addr;

  assign page    = bus.addr[ADDR_W-1 -: PAGE_BITS];
  assign look    = tbl[bus.ctx][page];
  assign t_valid = look[E_W-1];
  assign t_wp    = look[E_W-2];
  assign t_fault = bus.paging_en && (!t_valid || (bus.we && t_wp));

  always_comb begin
    t_addr = '0;
    if (!bus.paging_en)
      t_addr = {{(EXT_W-ADDR_W){1'b0}}, bus.addr};
    else if (!t_fault)
      t_addr = {look[PHYS_PAGE_W-1:0], bus.addr[OFF_W-1:0]};
  end

  assign bus.busy  = (state == S_FLUSH);
  assign bus.ready = (state == S_IDLE);
  assign accept    = bus.req && bus.ready;

  // Flush clear is issued first so a same-entry SR write overrides it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tbl <= '{default: '0};
    end else begin
      if (state == S_FLUSH)
        tbl[fctx][idx][E_W-1] <= 1'b0;
      if (in_win)
        tbl[wr_ctx][win_idx] <= new_ent;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      fctx   <= '0;
      wr_ctx <= '0;
    end else begin
      if (bus.sr_ie && (bus.sr_sel == CTX_SEL))
        wr_ctx <= bus.sr_data[CTX_W-1:0];
      case (state)
        S_IDLE: if (bus.flush) begin
          state <= S_FLUSH;
          fctx  <= bus.flush_ctx;
          idx   <= '0;
        end
        default: begin
          idx <= idx + 1'b1;
          if (idx == PAGE_BITS'(ENT - 1))
            state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.ack      <= 1'b0;
      bus.ext_addr <= '0;
      bus.fault    <= 1'b0;
    end else begin
      bus.ack <= accept;
      if (accept) begin
        bus.ext_addr <= t_addr;
        bus.fault    <= t_fault;
      end
    end
  end

  logic unused_sr;
  assign unused_sr = ^{bus.sr_data, sel_off};

`ifdef MMU_FAULT_LATCH_EN
  logic [ADDR_W-1:0] r_vaddr;
  logic [CTX_W+1:0]  r_info;
  logic              lat_v;

  // r_* shadow the request whose result is on the outputs this cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vaddr        <= '0;
      r_info         <= '0;
      lat_v          <= 1'b0;
      bus.fault_addr <= '0;
      bus.fault_info <= '0;
    end else begin
      if (accept) begin
        r_vaddr <= bus.addr;
        r_info  <= {bus.ctx, bus.we, bus.paging_en && t_valid && bus.we && t_wp};
      end
      if (bus.fault_clr) begin
        lat_v          <= 1'b0;
        bus.fault_addr <= '0;
        bus.fault_info <= '0;
      end
      if (bus.ack && bus.fault && (!lat_v || bus.fault_clr)) begin
        lat_v          <= 1'b1;
        bus.fault_addr <= r_vaddr;
        bus.fault_info <= r_info;
      end
    end
  end
`else
  assign bus.fault_addr = '0;
  assign bus.fault_info = '0;
  logic unused_clr;
  assign unused_clr = bus.fault_clr;
`endif
endmodule
